// File: rtl/echo_request_input.sv
// Host-to-hardware request portal for Echo: parses host words into `say` calls,
// buffers decoded calls in a small FIFO and drives the Echo `say` RDY/ENA handshake.
module echo_request_input #(
  parameter int FIFO_DEPTH = 4,
  parameter int SAY_METHOD = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] requests_0_enq_v,
  input  logic        EN_requests_0_enq,
  output logic        RDY_requests_0_enq,
  output logic        requests_0_notFull,
  output logic        RDY_requests_0_notFull,
  input  logic [15:0] messageSize_size_methodNumber,
  output logic [15:0] messageSize_size,
  output logic        RDY_messageSize_size,
  output logic        intr_status,
  output logic        RDY_intr_status,
  output logic [31:0] intr_channel,
  output logic        RDY_intr_channel,
  input  logic        say__RDY,
  output logic        say__ENA,
  output logic [31:0] say_v,
  output logic [15:0] err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [15:0] SAY_M = 16'(SAY_METHOD);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DISC = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [15:0]   remaining_r;
  logic [15:0]   err_r;
  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic        full_s;
  logic        empty_s;
  logic        accept_s;
  logic        pop_s;
  logic        push_s;
  logic        hdr_valid_s;
  logic        err_inc_s;
  logic        load_rem_s;
  logic        dec_rem_s;
  logic [15:0] hdr_method_s;
  logic [15:0] hdr_len_s;

  assign full_s       = (count_r == DEPTH_C);
  assign empty_s      = (count_r == {CW{1'b0}});
  assign accept_s     = EN_requests_0_enq && !full_s;
  assign pop_s        = !empty_s && say__RDY;
  assign hdr_method_s = requests_0_enq_v[31:16];
  assign hdr_len_s    = requests_0_enq_v[15:0];
  assign hdr_valid_s  = (hdr_method_s == SAY_M) && (hdr_len_s == 16'd1);

  assign RDY_requests_0_enq     = !full_s;
  assign requests_0_notFull     = !full_s;
  assign RDY_requests_0_notFull = 1'b1;
  assign messageSize_size       = (messageSize_size_methodNumber == SAY_M) ? 16'd32 : 16'd0;
  assign RDY_messageSize_size   = 1'b1;
  assign intr_status            = 1'b0;
  assign RDY_intr_status        = 1'b1;
  assign intr_channel           = 32'hFFFF_FFFF;
  assign RDY_intr_channel       = 1'b1;
  assign say__ENA               = pop_s;
  assign say_v                  = mem_r[rd_ptr_r];
  assign err_count              = err_r;

  // Message parser: next state and per-word actions
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    err_inc_s    = 1'b0;
    load_rem_s   = 1'b0;
    dec_rem_s    = 1'b0;
    case (state_r)
      HDR: begin
        if (accept_s) begin
          if (hdr_valid_s) begin
            next_state_s = PAY;
          end else begin
            err_inc_s = 1'b1;
            if (hdr_len_s != 16'd0) begin
              load_rem_s   = 1'b1;
              next_state_s = DISC;
            end else begin
              next_state_s = HDR;
            end
          end
        end else begin
          next_state_s = HDR;
        end
      end
      PAY: begin
        if (accept_s) begin
          push_s       = 1'b1;
          next_state_s = HDR;
        end else begin
          next_state_s = PAY;
        end
      end
      DISC: begin
        if (accept_s) begin
          dec_rem_s = 1'b1;
          if (remaining_r == 16'd1) begin
            next_state_s = HDR;
          end else begin
            next_state_s = DISC;
          end
        end else begin
          next_state_s = DISC;
        end
      end
      default: begin
        next_state_s = HDR;
      end
    endcase
  end

  // Parser state, discard counter and saturating error counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= HDR;
      remaining_r <= 16'd0;
      err_r       <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if (load_rem_s) begin
        remaining_r <= hdr_len_s;
      end else if (dec_rem_s) begin
        remaining_r <= remaining_r - 16'd1;
      end
      if (err_inc_s && (err_r != 16'hFFFF)) begin
        err_r <= err_r + 16'd1;
      end
    end
  end

  // Decoded-call FIFO; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= requests_0_enq_v;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/echo_request_input.md
Name: echo_request_input

Overview:
- Host-to-hardware request portal for the Echo example. It is the inbound counterpart of the indication output block.
- Accepts 32-bit words pushed by the host through the requests_0 enq channel and parses each message header.
- Assembles each payload into a decoded `say` call and buffers calls in a small FIFO.
- Drives the Echo `say` method with a RDY/ENA handshake.
- Sits between the host portal transport and the Echo core inside the top-level Echo wrapper.

Parameters:
- FIFO_DEPTH, 4: decoded-call buffer depth in entries; must be a power of 2, ≥2.
- SAY_METHOD, 0: method number decoded as `say`.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- requests_0_enq_v  input  32  host word.
- EN_requests_0_enq  input  1  host pushes requests_0_enq_v this cycle.
- RDY_requests_0_enq  output  1  word can be accepted.
- requests_0_notFull  output  1  same value as RDY_requests_0_enq.
- RDY_requests_0_notFull  output  1  constant 1.
- messageSize_size_methodNumber  input  16  method queried.
- messageSize_size  output  16  payload size in bits of the queried method.
- RDY_messageSize_size  output  1  constant 1.
- intr_status  output  1  constant 0; request portals never interrupt.
- RDY_intr_status  output  1  constant 1.
- intr_channel  output  32  constant 32'hFFFFFFFF.
- RDY_intr_channel  output  1  constant 1.
- say__RDY  input  1  Echo can accept `say`.
- say__ENA  output  1  `say` fires this cycle.
- say_v  output  32  `say` argument.
- err_count  output  16  malformed-message counter, saturating.

Behaviour:
- Message format:
  - Header word: [31:16] method number; [15:0] payload word count N.
  - The header is followed by N payload words.
  - The only valid message is method==SAY_METHOD with N==1.
- Word acceptance:
  - RDY_requests_0_enq = !fifo_full.
  - A word is accepted only when EN_requests_0_enq && RDY_requests_0_enq.
  - EN while not RDY has no effect: the word is dropped and no state changes.
- FSM states (reset to HDR):
  - HDR:
    - Accepted word is the header; latch method and N.
    - Valid header → PAY.
    - Invalid header with N==0 → err_count+1, stay in HDR.
    - Invalid header with N>0 → err_count+1, load remaining=N → DISC.
  - PAY:
    - Accepted word is pushed into the FIFO at the same edge → HDR.
  - DISC:
    - Each accepted word decrements remaining.
    - When remaining reaches 1 and a word is accepted → HDR.
    - Discarded words are never pushed.
- err_count saturates at 16'hFFFF.
- FIFO: circular buffer of FIFO_DEPTH×32 with wrapping read/write pointers and an occupancy count of clog2(FIFO_DEPTH)+1 bits.
  - fifo_full when count==FIFO_DEPTH.
  - empty when count==0.
- Output handshake:
  - say__ENA = !empty && say__RDY (combinational).
  - say_v = FIFO head; valid whenever !empty.
  - On say__ENA, the head is popped at the edge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - A push is impossible when full at cycle start, because RDY is low.
  - A pop in that same cycle does not enable a push until the next cycle.
- Latency: payload accepted at edge T → say__ENA can be high in cycle T+1. Two host words give one call.
- Throughput: one call per 2 host cycles when say__RDY is held high.
- messageSize_size (combinational):
  - 16'd32 when methodNumber==SAY_METHOD.
  - 16'd0 otherwise.
- Reset (asynchronous, any time, including mid-message):
  - FSM=HDR, pointers/count=0, remaining=0, err_count=0.
  - Partial message and buffered calls are discarded.
  - Outputs after reset: RDY_requests_0_enq=1, requests_0_notFull=1, say__ENA=0.
  - say_v is don't-care while empty; registered data is cleared to 0.
- Reset release: a word presented in the first cycle after RST_N rises is accepted normally.

Test Plan:
- Reset, then push 32'h0000_0001 and 32'hDEAD_BEEF with say__RDY=1 → say__ENA one cycle after the payload edge with say_v=32'hDEADBEEF; err_count=0.
- say__RDY=0; push 4 valid messages (payloads 1,2,3,4) → RDY_requests_0_enq low after the 4th payload; a further header with EN high is dropped. Raise say__RDY → say_v sequence 1,2,3,4, one per cycle, RDY returns high after the first pop.
- Push header 32'h0005_0003 then 3 words, then a valid say with 32'h12345678 → err_count=1; no say for the discarded words; one say with 32'h12345678.
- Headers 32'h0000_0000 and 32'h0007_0000 → err_count=2, FSM stays in HDR; the next valid message decodes correctly.
- Push a header only, assert RST_N=0 asynchronously mid-cycle, release, then send a valid say with 32'hA5A5A5A5 → exactly one say with 32'hA5A5A5A5; the stale header is ignored.
- messageSize_size_methodNumber=0 → 32; =3 → 0. intr_status=0, intr_channel=32'hFFFFFFFF throughout.
